// File: rtl/fjr_pkg.sv
// Shared definitions for the factorial-accelerator job runner: FSM states,
// accelerator register offsets and STATUS bit positions.
package fjr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_N,
    ST_WR_GO,
    ST_WR_GO_CLR,
    ST_POLL,
    ST_RD_RES,
    ST_WR_MEM,
    ST_DONE
  } fjr_state_t;

  localparam logic [31:0] FJR_OFF_N      = 32'h0000_0000;
  localparam logic [31:0] FJR_OFF_GO     = 32'h0000_0004;
  localparam logic [31:0] FJR_OFF_STATUS = 32'h0000_0008;
  localparam logic [31:0] FJR_OFF_RESULT = 32'h0000_000C;

  localparam int FJR_ST_DONE = 0;
  localparam int FJR_ST_ERR  = 1;

endpackage

// File: rtl/fjr_bus_drv.sv
// Registered bus-output stage: captures one access request per cycle and
// presents it to the SoC bus; an invalid request parks the bus at all-zero.
module fjr_bus_drv (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_we    <= 1'b0;
    end else if (req_valid) begin
      bus_addr  <= req_addr;
      bus_wdata <= req_we ? req_wdata : 32'h0;
      bus_we    <= req_we;
    end else begin
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_we    <= 1'b0;
    end
  end

endmodule

// File: rtl/faccel_job_runner.sv
// Bus-master sequencer running one factorial job per start pulse.
// Optional poll timeout is compiled in with FJR_TIMEOUT_EN.
module faccel_job_runner #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] FACT_BASE      = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  n,
  input  logic [31:0] dst_addr,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);
  import fjr_pkg::*;

  fjr_state_t  state, state_next;
  logic [29:0] dst_word;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        status_done, status_err, timeout_hit;
  logic        unused_bits;

  assign unused_bits = ^dst_addr[1:0];
  assign status_done = bus_rdata[FJR_ST_DONE];
  assign status_err  = bus_rdata[FJR_ST_ERR];

`ifdef FJR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] poll_cnt;
  assign timeout_hit = (poll_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_WR_N;
      ST_WR_N:      state_next = ST_WR_GO;
      ST_WR_GO:     state_next = ST_WR_GO_CLR;
      ST_WR_GO_CLR: state_next = ST_POLL;
      ST_POLL: begin
        if (status_err)       state_next = ST_DONE;
        else if (status_done) state_next = ST_RD_RES;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_RD_RES:    state_next = ST_WR_MEM;
      ST_WR_MEM:    state_next = ST_DONE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // The request is decoded from the next state so the registered bus stage
  // presents each access during the very cycle the FSM sits in that state.
  // WR_N is only reached from IDLE, so n is taken straight from the port, and
  // WR_MEM only from RD_RES, so the data is the RESULT value on the bus now.
  always_comb begin
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    case (state_next)
      ST_WR_N: begin
        req_we    = 1'b1;
        req_addr  = FACT_BASE + FJR_OFF_N;
        req_wdata = {28'b0, n};
      end
      ST_WR_GO: begin
        req_we    = 1'b1;
        req_addr  = FACT_BASE + FJR_OFF_GO;
        req_wdata = 32'h1;
      end
      ST_WR_GO_CLR: begin
        req_we    = 1'b1;
        req_addr  = FACT_BASE + FJR_OFF_GO;
      end
      ST_POLL:   req_addr = FACT_BASE + FJR_OFF_STATUS;
      ST_RD_RES: req_addr = FACT_BASE + FJR_OFF_RESULT;
      ST_WR_MEM: begin
        req_we    = 1'b1;
        req_addr  = {dst_word, 2'b00};
        req_wdata = bus_rdata;
      end
      default:   req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      dst_word <= 30'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= 32'h0;
`ifdef FJR_TIMEOUT_EN
      poll_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);
      if (state == ST_IDLE && start) begin
        err      <= 1'b0;
        dst_word <= dst_addr[31:2];
      end
      if (state == ST_POLL && (status_err || (!status_done && timeout_hit)))
        err <= 1'b1;
      if (state == ST_RD_RES)
        result <= bus_rdata;
`ifdef FJR_TIMEOUT_EN
      if (state == ST_WR_GO_CLR)
        poll_cnt <= '0;
      else if (state == ST_POLL)
        poll_cnt <= poll_cnt + 1'b1;
`endif
    end
  end

  fjr_bus_drv u_bus_drv (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we)
  );

endmodule

// File: doc/faccel_job_runner.md
# faccel_job_runner

Bus-master sequencer that sits directly upstream of the SoC memory-mapped bus. It drives the SoC's `addr`, `write_data` and `WE` inputs and reads back the SoC's `data_out`. On a single `start` pulse it runs one factorial job end-to-end:

- programs the factorial accelerator and starts it;
- polls the accelerator until it reports done;
- reads the result and stores it to a caller-supplied dmem address.

It replaces hand-written processor polling loops for accelerator jobs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum number of POLL reads before the job aborts; used only with `FJR_TIMEOUT_EN`.
- `FACT_BASE`, 32'h0000_0800: base address of the factorial accelerator.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: job request. Sampled only in IDLE.
- `n` in 4: factorial operand.
- `dst_addr` in 32: dmem word address for the result; `[1:0]` ignored.
- `bus_rdata` in 32: SoC `data_out`, combinational from `bus_addr`.
- `bus_addr` out 32: SoC `addr`.
- `bus_wdata` out 32: SoC `write_data`.
- `bus_we` out 1: SoC `WE`.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is left.
- `done` out 1: one-cycle pulse at the end of every job, success or failure.
- `err` out 1: valid with `done`, held until the next `start`. Set on accelerator error or timeout.
- `result` out 32: last successful result, held until overwritten.

## Operation
Accelerator registers are at `FACT_BASE` plus: +0x0 N, +0x4 GO, +0x8 STATUS, +0xC RESULT. STATUS bit0 = done, bit1 = error.

States and actions:
- IDLE: bus idle (`bus_we`=0, `bus_addr`=0, `bus_wdata`=0). On `start`=1, latch `n` and `dst_addr`, clear `err`, go to WR_N.
- WR_N: write `{28'b0, n}` to +0x0. Go to WR_GO.
- WR_GO: write 1 to +0x4. Go to WR_GO_CLR.
- WR_GO_CLR: write 0 to +0x4. Clear the poll counter. Go to POLL.
- POLL: read +0x8 and sample `bus_rdata` at the clock edge.
  - bit1=1: set `err`, go to DONE.
  - else bit0=1: go to RD_RES.
  - else: increment the poll counter and stay in POLL.
- RD_RES: read +0xC and load `result` from `bus_rdata` at the edge. Go to WR_MEM.
- WR_MEM: write `result` to `{dst_addr[31:2], 2'b00}`. Go to DONE.
- DONE: `done`=1 for this one cycle, bus idle. Go to IDLE.

Rules:
- `bus_we` is high only in WR_N, WR_GO, WR_GO_CLR and WR_MEM. In every read state `bus_we`=0 and `bus_wdata`=0.
- `start` while busy is ignored; it is not queued.
- `start` held high across DONE→IDLE launches a new job in the IDLE cycle.
- When the error bit is set, no dmem write occurs and `result` is unchanged.
- If STATUS reads bit0=1 and bit1=1 together, error takes priority.

## Timing
- Reset values: state=IDLE, `bus_addr`=0, `bus_wdata`=0, `bus_we`=0, `busy`=0, `done`=0, `err`=0, `result`=0. All bus outputs are registered.
- Reset asserted mid-job: forces IDLE asynchronously and drops `bus_we` immediately. The accelerator is left in whatever state it was in; the next job re-programs N and GO.
- Minimum job latency, `start` edge to `done` high: 7 cycles (WR_N, WR_GO, WR_GO_CLR, one POLL, RD_RES, WR_MEM, DONE).
- Each additional POLL cycle adds 1.
- Every bus access lasts exactly one cycle. Address and data are stable for the whole cycle.

## Configuration
- `FJR_TIMEOUT_EN` defined: a poll counter of width $clog2(TIMEOUT_CYCLES+1) is compiled in. When the counter reaches `TIMEOUT_CYCLES` in POLL without done, set `err` and go to DONE.
- Not defined: no counter is present. POLL waits indefinitely; `err` is set only by STATUS bit1.

## Structure
- Shared package `fjr_pkg` holds:
  - the state enum;
  - register offsets `FJR_OFF_N`, `FJR_OFF_GO`, `FJR_OFF_STATUS`, `FJR_OFF_RESULT`;
  - STATUS bit indices `FJR_ST_DONE` and `FJR_ST_ERR`.
- One natural sub-module, `fjr_bus_drv`: registered bus-output stage that takes {valid, we, addr, wdata} from the FSM and registers it. Everything else lives in a single FSM module.

## Test plan
- Reset released; accelerator model returns done after 3 polls; `start` with n=5, dst_addr=0x40 → sequence:
  - writes 5@0x800, 1@0x804, 0@0x804;
  - 3 reads of 0x808 return 0, then done;
  - read 0x80C returns 120;
  - write 120@0x40;
  - `done` pulse with `err`=0 and `result`=120, 10 cycles after `start`.
- n=0, model done immediately → `result`=1 written to `dst_addr`; `done` 7 cycles after `start`.
- Model returns STATUS=0x2 on the first poll → `err`=1 with `done`; no write to `dst_addr`; `result` holds its previous value.
- `FJR_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, model never done → 17 POLL reads, then `done` with `err`=1; no RESULT read and no dmem write.
- `reset` driven low during POLL, then `start` with n=3 → `bus_we` drops immediately; the new job writes 3@0x800 and completes with 6.
- `start` pulsed during WR_GO → ignored; exactly one `done` pulse.
